// File: rtl/pool_2.sv
// pool_2: second LeNet max-pool stage (2x2 window, stride 2).
// Reads DEEP maps of IN_SIZE x IN_SIZE conv2 results from the shared result
// BRAM, takes the signed maximum of each window and writes DEEP maps of
// OUT_SIZE x OUT_SIZE results back into the same BRAM.
// Optional feature macro: POOL2_RELU_EN -- when defined, negative maxima are
// clamped to zero before they are stored.
module pool_2 #(
  parameter int DEEP              = 50,
  parameter int IN_SIZE           = 8,
  parameter int OUT_SIZE          = 4,
  parameter int DATA_SIZE         = 8,
  parameter int CONV2_RESULT_BASE = 14400,
  parameter int POOL2_RESULT_BASE = 17600,
  parameter int RD_LAT            = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pool_2_en,
  input  logic [DATA_SIZE-1:0] result_bram_douta,
  output logic                 result_bram_ena,
  output logic                 result_bram_wea,
  output logic [14:0]          result_bram_addra,
  output logic [DATA_SIZE-1:0] result_bram_dina,
  output logic                 pool_2_finish
);

  localparam int CH_W = $clog2(DEEP + 1);
  localparam int RC_W = $clog2(OUT_SIZE);
  localparam int WT_W = $clog2(RD_LAT + 1);

  localparam logic [CH_W-1:0] CH_END   = CH_W'(DEEP);
  localparam logic [RC_W-1:0] RC_LAST  = RC_W'(OUT_SIZE - 1);
  localparam logic [WT_W-1:0] WT_LAST  = WT_W'(RD_LAT);
  localparam logic [14:0]     RD_BASE  = 15'(CONV2_RESULT_BASE);
  localparam logic [14:0]     WR_BASE  = 15'(POOL2_RESULT_BASE);
  localparam logic [14:0]     IN_AREA  = 15'(IN_SIZE * IN_SIZE);
  localparam logic [14:0]     OUT_AREA = 15'(OUT_SIZE * OUT_SIZE);
  localparam logic [14:0]     IN_EDGE  = 15'(IN_SIZE);
  localparam logic [14:0]     OUT_EDGE = 15'(OUT_SIZE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_LOAD    = 3'd2,
    S_COMPARE = 3'd3,
    S_STORE   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic [RC_W-1:0]              r_q, r_d;
  logic [RC_W-1:0]              col_q, col_d;
  logic [1:0]                   k_q, k_d;
  logic [WT_W-1:0]              wt_q, wt_d;
  logic signed [DATA_SIZE-1:0]  win_q [0:3];
  logic signed [DATA_SIZE-1:0]  win_d [0:3];
  logic signed [DATA_SIZE-1:0]  max_q, max_d;
  logic                         ena_q, ena_d;
  logic                         wea_q, wea_d;
  logic [14:0]                  addr_q, addr_d;
  logic [DATA_SIZE-1:0]         dina_q, dina_d;
  logic                         finish_q, finish_d;

  logic [14:0]                  rd_addr_s;
  logic [14:0]                  wr_addr_s;

  // Signed maximum of two words; on a tie both operands are equal anyway.
  function automatic logic signed [DATA_SIZE-1:0] smax(
    input logic signed [DATA_SIZE-1:0] a,
    input logic signed [DATA_SIZE-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Value stored for one window: signed max, optionally clamped at zero.
  function automatic logic signed [DATA_SIZE-1:0] pool_value(
    input logic signed [DATA_SIZE-1:0] w0,
    input logic signed [DATA_SIZE-1:0] w1,
    input logic signed [DATA_SIZE-1:0] w2,
    input logic signed [DATA_SIZE-1:0] w3
  );
    logic signed [DATA_SIZE-1:0] m;
    m = smax(smax(w0, w1), smax(w2, w3));
`ifdef POOL2_RELU_EN
    if (m[DATA_SIZE-1]) begin
      m = {DATA_SIZE{1'b0}};
    end else begin
      m = m;
    end
`endif
    return m;
  endfunction

  // Window element address (k = {dy,dx}) and output address for the current position.
  always_comb begin
    rd_addr_s = RD_BASE + 15'(ch_q) * IN_AREA
              + 15'({r_q, k_q[1]}) * IN_EDGE
              + 15'({col_q, k_q[0]});
    wr_addr_s = WR_BASE + 15'(ch_q) * OUT_AREA
              + 15'(r_q) * OUT_EDGE
              + 15'(col_q);
  end

  // Next-state and next-output logic; everything holds while the enable is low except DONE.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    r_d      = r_q;
    col_d    = col_q;
    k_d      = k_q;
    wt_d     = wt_q;
    win_d    = win_q;
    max_d    = max_q;
    ena_d    = ena_q;
    wea_d    = wea_q;
    addr_d   = addr_q;
    dina_d   = dina_q;
    finish_d = finish_q;

    if (!pool_2_en) begin
      if (state_q == S_DONE) begin
        finish_d = 1'b0;
        state_d  = S_IDLE;
      end else begin
        state_d  = state_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          ch_d     = {CH_W{1'b0}};
          r_d      = {RC_W{1'b0}};
          col_d    = {RC_W{1'b0}};
          k_d      = 2'd0;
          wt_d     = {WT_W{1'b0}};
          finish_d = 1'b0;
          state_d  = S_CHECK;
        end

        S_CHECK: begin
          if (ch_q == CH_END) begin
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            k_d     = 2'd0;
            wt_d    = {WT_W{1'b0}};
            state_d = S_LOAD;
          end
        end

        S_LOAD: begin
          // Issue the read for element k on its first wait cycle.
          if (wt_q == {WT_W{1'b0}}) begin
            ena_d  = 1'b1;
            wea_d  = 1'b0;
            addr_d = rd_addr_s;
          end else begin
            ena_d  = ena_q;
          end
          // Capture once the read latency has elapsed.
          if (wt_q == WT_LAST) begin
            win_d[k_q] = result_bram_douta;
            wt_d       = {WT_W{1'b0}};
            if (k_q == 2'd3) begin
              ena_d   = 1'b0;
              state_d = S_COMPARE;
            end else begin
              k_d     = k_q + 2'd1;
            end
          end else begin
            wt_d = wt_q + WT_W'(1);
          end
        end

        S_COMPARE: begin
          max_d   = pool_value(win_q[0], win_q[1], win_q[2], win_q[3]);
          wt_d    = {WT_W{1'b0}};
          state_d = S_STORE;
        end

        S_STORE: begin
          if (wt_q == {WT_W{1'b0}}) begin
            ena_d  = 1'b1;
            wea_d  = 1'b1;
            dina_d = max_q;
            addr_d = wr_addr_s;
          end else begin
            dina_d = dina_q;
          end
          if (wt_q == WT_LAST) begin
            ena_d   = 1'b0;
            wea_d   = 1'b0;
            wt_d    = {WT_W{1'b0}};
            state_d = S_CHECK;
            // Raster order: column fastest, then row, then channel.
            if (col_q == RC_LAST) begin
              col_d = {RC_W{1'b0}};
              if (r_q == RC_LAST) begin
                r_d  = {RC_W{1'b0}};
                ch_d = ch_q + CH_W'(1);
              end else begin
                r_d  = r_q + RC_W'(1);
              end
            end else begin
              col_d = col_q + RC_W'(1);
            end
          end else begin
            wt_d = wt_q + WT_W'(1);
          end
        end

        S_DONE: begin
          finish_d = 1'b1;
          state_d  = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, counters, window buffer and registered BRAM interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= {CH_W{1'b0}};
      r_q      <= {RC_W{1'b0}};
      col_q    <= {RC_W{1'b0}};
      k_q      <= 2'd0;
      wt_q     <= {WT_W{1'b0}};
      win_q    <= '{default: {DATA_SIZE{1'b0}}};
      max_q    <= {DATA_SIZE{1'b0}};
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= 15'd0;
      dina_q   <= {DATA_SIZE{1'b0}};
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      r_q      <= r_d;
      col_q    <= col_d;
      k_q      <= k_d;
      wt_q     <= wt_d;
      win_q    <= win_d;
      max_q    <= max_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
      finish_q <= finish_d;
    end
  end

  assign result_bram_ena   = ena_q;
  assign result_bram_wea   = wea_q;
  assign result_bram_addra = addr_q;
  assign result_bram_dina  = dina_q;
  assign pool_2_finish     = finish_q;

endmodule

// File: tb/tb_pool_2.sv
// Bench for pool_2: BRAM model with 3-cycle read path, access monitor,
// table of hand-computed windows, random maps checked against a
// plain-arithmetic pooling model, enable-freeze and mid-layer reset runs.
module tb_pool_2;

  localparam int N_OUT   = 800;
  localparam int RD_BASE = 14400;
  localparam int WR_BASE = 17600;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  douta;
  logic        ena;
  logic        wea;
  logic [14:0] addra;
  logic [7:0]  dina;
  logic        finish;

  pool_2 dut (
    .clk               (clk),
    .rst               (rst),
    .pool_2_en         (en),
    .result_bram_douta (douta),
    .result_bram_ena   (ena),
    .result_bram_wea   (wea),
    .result_bram_addra (addra),
    .result_bram_dina  (dina),
    .pool_2_finish     (finish)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:32767];
  logic [7:0] img [0:32767];
  logic [7:0] rd_pipe;
  logic       load_req;

  // BRAM model: address sampled, then output register (data valid 2 edges after ena/addr seen).
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = RD_BASE; i < WR_BASE + N_OUT; i++) mem[i] <= img[i];
    end else if (ena) begin
      if (wea) mem[addra] <= dina;
      else     rd_pipe    <= mem[addra];
    end
    douta <= rd_pipe;
  end

  int   rd_q[$];
  int   wr_q[$];
  int   bad_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wea = 1'b0;
  logic [14:0] prev_addr = 15'd0;

  // Access monitor: address ranges, read sequence and write windows.
  always @(negedge clk) begin
    if ((ena && !wea && (32'(addra) < RD_BASE || 32'(addra) >= WR_BASE)) ||
        (wea && (!ena || 32'(addra) < WR_BASE || 32'(addra) >= WR_BASE + N_OUT)))
      bad_cnt <= bad_cnt + 1;
    if (ena && !wea && (!prev_rd || addra != prev_addr)) rd_q.push_back(32'(addra));
    if (wea && !prev_wea) wr_q.push_back(32'(addra));
    prev_rd   <= ena && !wea;
    prev_wea  <= wea;
    prev_addr <= addra;
  end

  int nvec = 0;
  int nbad = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: plain arithmetic from the layer definition.
  function automatic int win_addr(input int o, input int k);
    int ch, r, col;
    ch  = o / 16;
    r   = (o % 16) / 4;
    col = o % 4;
    return RD_BASE + ch * 64 + (2 * r + k / 2) * 8 + 2 * col + k % 2;
  endfunction

  function automatic int ref_pool(input int o);
    int m, v;
    m = -1000;
    for (int k = 0; k < 4; k++) begin
      v = int'($signed(img[win_addr(o, k)]));
      if (v > m) m = v;
    end
`ifdef POOL2_RELU_EN
    if (m < 0) m = 0;
`endif
    return m & 255;
  endfunction

  typedef struct {
    int             o;
    logic [3:0][7:0] w;      // {w3,w2,w1,w0}, w0 = (0,0)
    logic [7:0]     raw;
    logic [7:0]     relu;
  } vec_t;

  vec_t tbl [8];
  int   exp_out [N_OUT];
  int   fz_cyc [3];
  int   fz_exp [3];

  task automatic build_image(input logic [7:0] sentinel);
    for (int i = RD_BASE; i < WR_BASE; i++) img[i] = 8'($urandom);
    for (int i = WR_BASE; i < WR_BASE + N_OUT; i++) img[i] = sentinel;
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 4; k++) img[win_addr(tbl[t].o, k)] = tbl[t].w[k];
    for (int o = 0; o < N_OUT; o++) exp_out[o] = ref_pool(o);
  endtask

  task automatic do_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic freeze(input int exp);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("freeze_hold", 32'({ena, wea, finish, addra, dina}), exp);
    end
    en = 1'b1;
  endtask

  task automatic run_layer(input int rst_at);
    int cyc, fin, rd_base, wr_base, bad0, bad, nrd, nwr;
    logic did_rst;
    rd_base = rd_q.size();
    wr_base = wr_q.size();
    bad0    = bad_cnt;
    cyc = 0; fin = 0; did_rst = 1'b0;
    en = 1'b1;
    while (fin == 0 && cyc < 20000) begin
      @(posedge clk); #1;
      load_req = 1'b0;
      cyc++;
      if (finish) fin = cyc;
      for (int f = 0; f < 3; f++)
        if (fz_cyc[f] == cyc) freeze(fz_exp[f]);
      if (!did_rst && cyc == rst_at) begin
        did_rst = 1'b1;
        check("store_before_rst", 32'(wea), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_outputs", 32'({ena, wea, finish, addra, dina}), 0);
        rst = 1'b0;
        for (int i = WR_BASE; i < WR_BASE + N_OUT; i++) img[i] = 8'hC3;
        load_req = 1'b1;
        rd_base = rd_q.size();
        wr_base = wr_q.size();
        cyc = 0;
      end
    end
    check("finish_cycle", fin, 17602);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("finish_hold", 32'(finish), 1);
    end
    en = 1'b0;
    @(posedge clk); #1;
    check("finish_drop", 32'(finish), 0);
    @(posedge clk); #1;
    check("idle_quiet", 32'({ena, wea, finish}), 0);

    nwr = wr_q.size() - wr_base;
    nrd = rd_q.size() - rd_base;
    check("write_count", nwr, N_OUT);
    check("read_count", nrd, 4 * N_OUT);
    bad = 0;
    for (int i = 0; i < nwr && i < N_OUT; i++)
      if (wr_q[wr_base + i] != WR_BASE + i) bad++;
    check("write_order", bad, 0);
    bad = 0;
    for (int i = 0; i < nrd && i < 4 * N_OUT; i++)
      if (rd_q[rd_base + i] != win_addr(i / 4, i % 4)) bad++;
    check("read_order", bad, 0);
    bad = 0;
    for (int o = 0; o < N_OUT; o++)
      if (32'(mem[WR_BASE + o]) != exp_out[o]) begin
        if (bad == 0) $display("first image difference at %0d: got 0x%0h expected 0x%0h",
                               WR_BASE + o, mem[WR_BASE + o], exp_out[o]);
        bad++;
      end
    check("image", bad, 0);
    check("access_range", bad_cnt - bad0, 0);
  endtask

  initial begin
    int e;
    tbl[0] = '{0,   {8'h05, 8'hFE, 8'h07, 8'h03}, 8'h07, 8'h07};
    tbl[1] = '{1,   {8'h81, 8'hFE, 8'h80, 8'hFF}, 8'hFF, 8'h00};
    tbl[2] = '{799, {8'h80, 8'h80, 8'h80, 8'h80}, 8'h80, 8'h00};
    tbl[3] = '{5,   {8'h00, 8'h7F, 8'h80, 8'h7F}, 8'h7F, 8'h7F};
    tbl[4] = '{100, {8'hFF, 8'hFF, 8'hFF, 8'h00}, 8'h00, 8'h00};
    tbl[5] = '{400, {8'h40, 8'h30, 8'h20, 8'h10}, 8'h40, 8'h40};
    tbl[6] = '{17,  {8'h84, 8'h83, 8'h82, 8'h81}, 8'h84, 8'h00};
    tbl[7] = '{798, {8'h7E, 8'h7F, 8'h7E, 8'h01}, 8'h7F, 8'h7F};
    for (int f = 0; f < 3; f++) begin fz_cyc[f] = 0; fz_exp[f] = 0; end

    rst = 1'b1; en = 1'b0; load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({ena, wea, finish, addra, dina}), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_no_en", 32'({ena, wea, finish}), 0);

    // Run A: uninterrupted layer with table windows overlaid on random maps.
    build_image(8'h5A);
    do_load();
    run_layer(0);
    for (int t = 0; t < 8; t++) begin
`ifdef POOL2_RELU_EN
      e = 32'(tbl[t].relu);
`else
      e = 32'(tbl[t].raw);
`endif
      check($sformatf("table_vec%0d", t), 32'(mem[WR_BASE + tbl[t].o]), e);
    end
    check("last_rd0", rd_q[rd_q.size() - 4], 17590);
    check("last_rd1", rd_q[rd_q.size() - 3], 17591);
    check("last_rd2", rd_q[rd_q.size() - 2], 17598);
    check("last_rd3", rd_q[rd_q.size() - 1], 17599);
    check("last_wr", wr_q[wr_q.size() - 1], 18399);

    // Run B: same maps, enable dropped for 10 cycles in LOAD (twice) and in STORE.
    for (int i = WR_BASE; i < WR_BASE + N_OUT; i++) img[i] = 8'hA5;
    fz_cyc[0] = 117;   fz_exp[0] = 32'({1'b1, 1'b0, 1'b0, 15'(win_addr(5, 1)),   8'(exp_out[4])});
    fz_cyc[1] = 9006;  fz_exp[1] = 32'({1'b1, 1'b0, 1'b0, 15'(win_addr(409, 1)), 8'(exp_out[408])});
    fz_cyc[2] = 13220; fz_exp[2] = 32'({1'b1, 1'b1, 1'b0, 15'(WR_BASE + 600),     8'(exp_out[600])});
    do_load();
    run_layer(0);
    for (int f = 0; f < 3; f++) fz_cyc[f] = 0;

    // Run C: fresh random maps, reset pulse during STORE of output 37, then full rerun.
    build_image(8'h3C);
    do_load();
    run_layer(835);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
